mon_sel_mux_n: RTL and testbench
================================

// Module: mon_sel_mux_n
// PURPOSE
//  Next-gen CPU->monitor trace mux: selects one of N_CORES trace streams (hash, new_inst, reset_seq, pkt_done, irq) for a monitor.
//  Registered outputs. Core switches happen only at a packet boundary, followed by a blanking gap, so the monitor never sees a spliced packet.
//  Sits between the N processor cores and each hardware monitor; one instance per monitor.
// PARAMETERS
//  N_CORES        4   number of cores (>=2)
//  SEL_W          2   select width, clog2(N_CORES)
//  HASH_W         4   per-core instruction hash width
//  BLANK_CYCLES   2   outputs forced 0 for this many cycles on a switch (>=1)
//  SWITCH_TIMEOUT 256 max cycles waiting for a boundary before a forced switch; 0 = never force
//  RESET_SEL      0   core selected out of reset
// PORTS
//  clk              in  1              clock
//  reset            in  1              synchronous, active-high
//  sel_req          in  SEL_W          requested core
//  sel_req_valid    in  1              1-cycle strobe; latches sel_req
//  hash_in          in  N_CORES*HASH_W core i at [i*HASH_W +: HASH_W]
//  new_inst_in      in  N_CORES        per-core new-instruction strobe
//  proc_reset_seq_in in N_CORES        per-core reset-sequence flag
//  pkt_done_in      in  N_CORES        per-core packet-done strobe
//  irq_in           in  N_CORES        per-core interrupt
//  hash_out         out HASH_W         selected hash
//  new_inst_out     out 1              selected new_inst
//  proc_reset_seq_out out 1            selected reset_seq
//  pkt_done_out     out 1              selected pkt_done
//  irq_out          out 1              selected irq
//  cur_sel          out SEL_W          core currently driving outputs
//  switch_pending   out 1              pending_sel != cur_sel
//  sel_err          out 1              sticky: out-of-range request seen
//  timeout_evt      out 1              1-cycle pulse on a forced switch
// BEHAVIOUR
//  Reset: all data outputs 0, cur_sel=pending_sel=RESET_SEL, state IDLE, sel_err=0, timeout_evt=0, timers 0.
//  Data path: outputs = stream[cur_sel] registered; 1-cycle latency. Forced to 0 in SWITCH.
//  sel_req_valid with sel_req>=N_CORES: ignored, sel_err<=1. Otherwise pending_sel<=sel_req; last request wins.
//  Request == cur_sel while a switch is pending cancels the switch.
//  FSM, evaluated on the selected core c:
//   IDLE:   new_inst_in[c] -> BUSY. Else if a switch is pending -> SWITCH.
//   BUSY:   pkt_done_in[c] or proc_reset_seq_in[c] -> boundary.
//           On boundary: -> SWITCH if a switch is pending, else IDLE. The boundary beat itself is still forwarded.
//           With a switch pending, a wait counter increments each cycle.
//           If SWITCH_TIMEOUT!=0 and the counter reaches SWITCH_TIMEOUT: -> SWITCH, pulse timeout_evt.
//           Counter clears on leaving BUSY.
//   SWITCH: lasts exactly BLANK_CYCLES cycles.
//           On the last cycle: cur_sel<=pending_sel, -> IDLE.
//           Requests arriving in SWITCH update pending_sel. The target is sampled at exit; a further change causes a new switch later.
//  Same-cycle request + boundary: the new request is used for the boundary decision.
//  switch_pending reflects the registered pending_sel.
//  Other cores' strobes are ignored; no buffering, so their beats are lost while unselected (by design).
//  Reset mid-packet or mid-SWITCH: immediate return to reset state next cycle.
// CONFIGURATION
//  `MON_SEL_RR_EN defined:
//   - Adds input auto_rr (1b).
//   - While auto_rr=1, each boundary of core c with no explicit pending switch sets pending_sel=(c+1) mod N_CORES, then switches as above.
//   - An explicit valid request overrides the automatic target.
//  Not defined: no auto_rr port; switches only via sel_req.
// TESTING
//  1 Reset, N=4: outputs 0, cur_sel=0. Drive core0 hash=4'hA + new_inst -> hash_out=A, new_inst_out=1 one cycle later.
//  2 Core0 BUSY, req sel=2 -> no switch until pkt_done_in[0].
//    Then pkt_done_out=1, BLANK_CYCLES zero cycles, then cur_sel=2 carrying core2 data.
//  3 Req sel=5 with N=4 -> ignored, cur_sel unchanged, sel_err=1 until reset.
//  4 SWITCH_TIMEOUT=8, core1 BUSY forever, req sel=3 -> timeout_evt pulses after 8 cycles, switch to 3.
//  5 Req 1 then req 0 (==cur) before boundary -> switch_pending 1 then 0; no blanking.
//  6 `MON_SEL_RR_EN, auto_rr=1, pkt_done on each selected core -> cur_sel 0,1,2,3,0; reset mid-SWITCH -> cur_sel=RESET_SEL.

Source files
------------

// File: rtl/mon_sel_mux_n.sv
// Trace mux: forwards one core's trace stream to a monitor and switches cores only at packet boundaries, then blanks the outputs.
// Optional `MON_SEL_RR_EN adds an auto_rr input that rotates to the next core at each boundary.
//
// state  | meaning
// IDLE   | selected core between packets; a pending switch starts at once
// BUSY   | selected core inside a packet; waits for pkt_done/reset_seq or timeout
// SWITCH | outputs blanked for BLANK_CYCLES, cur_sel updated on the last one
module mon_sel_mux_n #(
    parameter int N_CORES        = 4,
    parameter int SEL_W          = 2,
    parameter int HASH_W         = 4,
    parameter int BLANK_CYCLES   = 2,
    parameter int SWITCH_TIMEOUT = 256,
    parameter int RESET_SEL      = 0
) (
    input  logic                      clk,
    input  logic                      reset,
`ifdef MON_SEL_RR_EN
    input  logic                      auto_rr,
`endif
    input  logic [SEL_W-1:0]          sel_req,
    input  logic                      sel_req_valid,
    input  logic [N_CORES*HASH_W-1:0] hash_in,
    input  logic [N_CORES-1:0]        new_inst_in,
    input  logic [N_CORES-1:0]        proc_reset_seq_in,
    input  logic [N_CORES-1:0]        pkt_done_in,
    input  logic [N_CORES-1:0]        irq_in,
    output logic [HASH_W-1:0]         hash_out,
    output logic                      new_inst_out,
    output logic                      proc_reset_seq_out,
    output logic                      pkt_done_out,
    output logic                      irq_out,
    output logic [SEL_W-1:0]          cur_sel,
    output logic                      switch_pending,
    output logic                      sel_err,
    output logic                      timeout_evt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    localparam int WAIT_W  = (SWITCH_TIMEOUT > 1) ? $clog2(SWITCH_TIMEOUT + 1) : 1;
    localparam int BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    localparam logic [SEL_W:0]     N_CORES_X   = (SEL_W + 1)'(N_CORES);
    localparam logic [SEL_W-1:0]   RESET_SEL_C = SEL_W'(RESET_SEL);
    localparam logic [WAIT_W-1:0]  WAIT_LAST   = WAIT_W'(SWITCH_TIMEOUT - 1);
    localparam logic [BLANK_W-1:0] BLANK_LOAD  = BLANK_W'(BLANK_CYCLES - 1);

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    cur_sel_q, cur_sel_d;
    logic [SEL_W-1:0]    pending_sel_q, pending_sel_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [BLANK_W-1:0]  blank_cnt_q, blank_cnt_d;
    logic                sel_err_q, sel_err_d;
    logic                timeout_evt_q, timeout_evt_d;
    logic [HASH_W-1:0]   hash_q, hash_d;
    logic                new_inst_q, new_inst_d;
    logic                reset_seq_q, reset_seq_d;
    logic                pkt_done_q, pkt_done_d;
    logic                irq_q, irq_d;

    logic [HASH_W-1:0]   sel_hash;
    logic                sel_new_inst;
    logic                sel_reset_seq;
    logic                sel_pkt_done;
    logic                sel_irq;
    logic                req_ok;
    logic                boundary;
    logic                want_switch;
    logic [SEL_W-1:0]    target;

    always_comb begin
        sel_hash      = '0;
        sel_new_inst  = 1'b0;
        sel_reset_seq = 1'b0;
        sel_pkt_done  = 1'b0;
        sel_irq       = 1'b0;
        for (int i = 0; i < N_CORES; i++) begin
            if (cur_sel_q == SEL_W'(i)) begin
                sel_hash      = hash_in[i*HASH_W +: HASH_W];
                sel_new_inst  = new_inst_in[i];
                sel_reset_seq = proc_reset_seq_in[i];
                sel_pkt_done  = pkt_done_in[i];
                sel_irq       = irq_in[i];
            end
        end
    end

    // A same-cycle request already counts as the target for this cycle's decision.
    always_comb begin
        req_ok   = sel_req_valid && ({1'b0, sel_req} < N_CORES_X);
        boundary = sel_pkt_done | sel_reset_seq;
        target   = req_ok ? sel_req : pending_sel_q;
`ifdef MON_SEL_RR_EN
        if ((state_q == ST_BUSY) && boundary && auto_rr && !req_ok &&
            (pending_sel_q == cur_sel_q)) begin
            target = (cur_sel_q == SEL_W'(N_CORES - 1)) ? '0 : cur_sel_q + SEL_W'(1);
        end
`endif
        want_switch = (target != cur_sel_q);
    end

    always_comb begin
        state_d       = state_q;
        cur_sel_d     = cur_sel_q;
        pending_sel_d = target;
        wait_cnt_d    = '0;
        blank_cnt_d   = BLANK_LOAD;
        sel_err_d     = sel_err_q | (sel_req_valid & ~req_ok);
        timeout_evt_d = 1'b0;
        hash_d        = sel_hash;
        new_inst_d    = sel_new_inst;
        reset_seq_d   = sel_reset_seq;
        pkt_done_d    = sel_pkt_done;
        irq_d         = sel_irq;

        case (state_q)
            ST_IDLE: begin
                if (sel_new_inst) begin
                    state_d = ST_BUSY;
                end else if (want_switch) begin
                    state_d = ST_SWITCH;
                end
            end
            ST_BUSY: begin
                if (boundary) begin
                    state_d = want_switch ? ST_SWITCH : ST_IDLE;
                end else if ((SWITCH_TIMEOUT != 0) && (pending_sel_q != cur_sel_q)) begin
                    if ((wait_cnt_q == WAIT_LAST) && want_switch) begin
                        state_d       = ST_SWITCH;
                        timeout_evt_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
            end
            ST_SWITCH: begin
                hash_d      = '0;
                new_inst_d  = 1'b0;
                reset_seq_d = 1'b0;
                pkt_done_d  = 1'b0;
                irq_d       = 1'b0;
                if (blank_cnt_q == '0) begin
                    cur_sel_d = target;
                    state_d   = ST_IDLE;
                end else begin
                    blank_cnt_d = blank_cnt_q - BLANK_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cur_sel_q     <= RESET_SEL_C;
            pending_sel_q <= RESET_SEL_C;
            wait_cnt_q    <= '0;
            blank_cnt_q   <= '0;
            sel_err_q     <= 1'b0;
            timeout_evt_q <= 1'b0;
            hash_q        <= '0;
            new_inst_q    <= 1'b0;
            reset_seq_q   <= 1'b0;
            pkt_done_q    <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_sel_q     <= cur_sel_d;
            pending_sel_q <= pending_sel_d;
            wait_cnt_q    <= wait_cnt_d;
            blank_cnt_q   <= blank_cnt_d;
            sel_err_q     <= sel_err_d;
            timeout_evt_q <= timeout_evt_d;
            hash_q        <= hash_d;
            new_inst_q    <= new_inst_d;
            reset_seq_q   <= reset_seq_d;
            pkt_done_q    <= pkt_done_d;
            irq_q         <= irq_d;
        end
    end

    assign hash_out           = hash_q;
    assign new_inst_out       = new_inst_q;
    assign proc_reset_seq_out = reset_seq_q;
    assign pkt_done_out       = pkt_done_q;
    assign irq_out            = irq_q;
    assign cur_sel            = cur_sel_q;
    assign switch_pending     = (pending_sel_q != cur_sel_q);
    assign sel_err            = sel_err_q;
    assign timeout_evt        = timeout_evt_q;

endmodule

// File: tb/tb_mon_sel_mux_n.sv
// Bench for mon_sel_mux_n: directed vector table, hand sequences for switch/timeout/cancel/reset,
// then random traffic against a cycle model; define MON_SEL_RR_EN to add the round-robin sequence.
module tb_mon_sel_mux_n;
    localparam int N  = 4;
    localparam int SW = 3;
    localparam int HW = 4;
    localparam int BL = 2;
    localparam int TO = 8;
    localparam int RS = 0;

    logic          clk = 1'b0;
    logic          reset;
`ifdef MON_SEL_RR_EN
    logic          auto_rr;
`endif
    logic [SW-1:0] sel_req;
    logic          sel_req_valid;
    logic [N*HW-1:0] hash_in;
    logic [N-1:0]  new_inst_in, proc_reset_seq_in, pkt_done_in, irq_in;
    logic [HW-1:0] hash_out;
    logic          new_inst_out, proc_reset_seq_out, pkt_done_out, irq_out;
    logic [SW-1:0] cur_sel;
    logic          switch_pending, sel_err, timeout_evt;

    mon_sel_mux_n #(.N_CORES(N), .SEL_W(SW), .HASH_W(HW), .BLANK_CYCLES(BL),
                    .SWITCH_TIMEOUT(TO), .RESET_SEL(RS)) dut (
        .clk(clk), .reset(reset),
`ifdef MON_SEL_RR_EN
        .auto_rr(auto_rr),
`endif
        .sel_req(sel_req), .sel_req_valid(sel_req_valid), .hash_in(hash_in),
        .new_inst_in(new_inst_in), .proc_reset_seq_in(proc_reset_seq_in),
        .pkt_done_in(pkt_done_in), .irq_in(irq_in), .hash_out(hash_out),
        .new_inst_out(new_inst_out), .proc_reset_seq_out(proc_reset_seq_out),
        .pkt_done_out(pkt_done_out), .irq_out(irq_out), .cur_sel(cur_sel),
        .switch_pending(switch_pending), .sel_err(sel_err), .timeout_evt(timeout_evt));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        v;
        logic [2:0]  req;
        logic [15:0] hash;
        logic [3:0]  ni, rs, pd, irq;
        logic [3:0]  e_hash;
        logic        e_ni, e_pd, e_irq;
        logic [2:0]  e_cur;
        logic        e_sp, e_err;
    } vec_t;
    vec_t tbl[11];

    // reference model state
    int       m_cur, m_pend, m_mode, m_blank, m_wait;
    bit       m_err;
    logic [13:0] m_exp;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [13:0] obs();
        return {hash_out, new_inst_out, proc_reset_seq_out, pkt_done_out, irq_out,
                cur_sel, switch_pending, sel_err, timeout_evt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [2:0] r, input logic [3:0] ni,
                          input logic [3:0] rs, input logic [3:0] pd);
        sel_req_valid     = v;
        sel_req           = r;
        new_inst_in       = ni;
        proc_reset_seq_in = rs;
        pkt_done_in       = pd;
        irq_in            = 4'b0;
    endtask

    task automatic model_reset();
        m_cur = RS; m_pend = RS; m_mode = 0; m_blank = 0; m_wait = 0; m_err = 0;
        m_exp = {4'h0, 4'h0, 3'(RS), 3'b000};
    endtask

    // mode 0: between packets, 1: in a packet, 2: blanking (m_blank cycles left)
    task automatic model_step();
        int tgt;
        bit ok, to;
        logic [3:0] h;
        logic o_ni, o_rs, o_pd, o_irq;
        if (reset) begin
            model_reset();
            return;
        end
        ok = sel_req_valid && (int'(sel_req) < N);
        if (sel_req_valid && !ok) m_err = 1;
        tgt = ok ? int'(sel_req) : m_pend;
        to  = 0;
        if (m_mode == 2) begin
            h = 0; o_ni = 0; o_rs = 0; o_pd = 0; o_irq = 0;
        end else begin
            h = hash_in[m_cur*HW +: HW];
            o_ni = new_inst_in[m_cur]; o_rs = proc_reset_seq_in[m_cur];
            o_pd = pkt_done_in[m_cur]; o_irq = irq_in[m_cur];
        end
        case (m_mode)
            0: begin
                if (new_inst_in[m_cur]) m_mode = 1;
                else if (tgt != m_cur) begin m_mode = 2; m_blank = BL; end
            end
            1: begin
                if (pkt_done_in[m_cur] || proc_reset_seq_in[m_cur]) begin
                    m_wait = 0;
                    if (tgt != m_cur) begin m_mode = 2; m_blank = BL; end
                    else m_mode = 0;
                end else if (m_pend != m_cur) begin
                    m_wait++;
                    if (m_wait >= TO && tgt != m_cur) begin
                        m_mode = 2; m_blank = BL; to = 1; m_wait = 0;
                    end
                end else begin
                    m_wait = 0;
                end
            end
            default: begin
                m_blank--;
                if (m_blank == 0) begin m_cur = tgt; m_mode = 0; end
            end
        endcase
        m_pend = tgt;
        m_exp = {h, o_ni, o_rs, o_pd, o_irq, 3'(m_cur), (m_pend != m_cur), m_err, to};
    endtask

    initial begin
        int k;
        tbl[0]  = '{1'b0, 3'd0, 16'h3C5A, 4'b0001, 4'b0, 4'b0,    4'b0,    4'hA, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 3'd2, 16'h3C5A, 4'b0,    4'b0, 4'b0,    4'b0,    4'hA, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 3'd0, 16'h3C5A, 4'b0,    4'b0, 4'b0,    4'b0,    4'hA, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 3'd0, 16'h3C5A, 4'b0,    4'b0, 4'b0001, 4'b0,    4'hA, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 3'd0, 16'h3C5A, 4'b0100, 4'b0, 4'b0,    4'b0100, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 3'd0, 16'h3C5A, 4'b0,    4'b0, 4'b0,    4'b0,    4'h0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 3'd0, 16'h3C5A, 4'b0100, 4'b0, 4'b0,    4'b0100, 4'hC, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 3'd5, 16'h3C5A, 4'b0,    4'b0, 4'b0001, 4'b0,    4'hC, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 3'd0, 16'h3C5A, 4'b0,    4'b0, 4'b0100, 4'b0,    4'hC, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 3'd0, 16'h3C5A, 4'b0010, 4'b0, 4'b0,    4'b0,    4'hC, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 3'd2, 16'h0F00, 4'b0,    4'b0, 4'b0,    4'b0,    4'hF, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1};

`ifdef MON_SEL_RR_EN
        auto_rr = 1'b0;
`endif
        reset   = 1'b1;
        hash_in = 16'h3C5A;
        set_in(1'b0, 3'd0, 4'b0, 4'b0, 4'b0);
        repeat (2) tick();
        check("reset_state", 16'(obs()), 16'h0000);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            set_in(tbl[i].v, tbl[i].req, tbl[i].ni, tbl[i].rs, tbl[i].pd);
            irq_in  = tbl[i].irq;
            hash_in = tbl[i].hash;
            tick();
            check($sformatf("vec%0d", i),
                  16'({hash_out, new_inst_out, pkt_done_out, irq_out, cur_sel, switch_pending, sel_err}),
                  16'({tbl[i].e_hash, tbl[i].e_ni, tbl[i].e_pd, tbl[i].e_irq, tbl[i].e_cur,
                       tbl[i].e_sp, tbl[i].e_err}));
        end

        // cancel: request 1 then 2 (== cur) while core2 is mid-packet
        hash_in = 16'h3C5A;
        set_in(1'b0, 3'd0, 4'b0100, 4'b0, 4'b0); tick();
        check("cancel_busy", 16'({hash_out, new_inst_out}), 16'h19);
        set_in(1'b1, 3'd1, 4'b0, 4'b0, 4'b0); tick();
        check("cancel_pend_set", 16'(switch_pending), 16'h1);
        set_in(1'b1, 3'd2, 4'b0, 4'b0, 4'b0); tick();
        check("cancel_pend_clr", 16'(switch_pending), 16'h0);
        set_in(1'b0, 3'd0, 4'b0, 4'b0, 4'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("cancel_no_blank", 16'({hash_out, cur_sel}), 16'({4'hC, 3'd2}));
        end
        set_in(1'b0, 3'd0, 4'b0, 4'b0100, 4'b0); tick();
        check("rs_boundary", 16'({proc_reset_seq_out, cur_sel}), 16'({1'b1, 3'd2}));
        set_in(1'b0, 3'd0, 4'b0, 4'b0, 4'b0); tick();
        check("rs_no_switch", 16'({hash_out, cur_sel, switch_pending}), 16'({4'hC, 3'd2, 1'b0}));

        // switch from IDLE to core1, then timeout while core1 never ends its packet
        set_in(1'b1, 3'd1, 4'b0, 4'b0, 4'b0); tick();
        check("idle_sw_req", 16'({hash_out, switch_pending}), 16'({4'hC, 1'b1}));
        set_in(1'b0, 3'd0, 4'b0, 4'b0, 4'b0); tick(); tick();
        check("idle_sw_done", 16'({hash_out, cur_sel}), 16'({4'h0, 3'd1}));
        set_in(1'b0, 3'd0, 4'b0010, 4'b0, 4'b0); tick();
        check("core1_busy", 16'({hash_out, new_inst_out}), 16'({4'h5, 1'b1}));
        set_in(1'b1, 3'd3, 4'b0, 4'b0, 4'b0); tick();
        check("to_req", 16'({hash_out, switch_pending}), 16'({4'h5, 1'b1}));
        set_in(1'b0, 3'd0, 4'b0, 4'b0, 4'b0);
        k = 0;
        while (k < 30) begin
            k++;
            tick();
            if (timeout_evt) break;
        end
        check("to_latency", 16'(k), 16'(TO));
        check("to_last_beat", 16'({hash_out, cur_sel}), 16'({4'h5, 3'd1}));
        tick();
        check("to_pulse_end", 16'({timeout_evt, hash_out}), 16'h0);
        tick();
        check("to_cur", 16'({hash_out, cur_sel}), 16'({4'h0, 3'd3}));
        tick();
        check("to_core3_data", 16'({hash_out, cur_sel, sel_err}), 16'({4'h3, 3'd3, 1'b1}));

        // reset in the middle of a blanking gap
        set_in(1'b1, 3'd0, 4'b0, 4'b0, 4'b0); tick();
        check("rst_sw_start", 16'(switch_pending), 16'h1);
        set_in(1'b0, 3'd0, 4'b0, 4'b0, 4'b0);
        reset = 1'b1; tick();
        check("rst_mid_switch", 16'(obs()), 16'({4'h0, 4'h0, 3'(RS), 3'b000}));
        reset = 1'b0;
        model_reset();

        for (int cyc = 0; cyc < 3000; cyc++) begin
            int pd_div;
            pd_div = (cyc < 1500) ? 4 : 40;
            reset = ($urandom_range(0, 299) == 0);
            sel_req_valid = ($urandom_range(0, 9) == 0);
            sel_req = 3'($urandom_range(0, 5));
            hash_in = 16'($urandom);
            new_inst_in = 4'($urandom);
            irq_in = 4'($urandom);
            for (int b = 0; b < N; b++) begin
                proc_reset_seq_in[b] = ($urandom_range(0, 15) == 0);
                pkt_done_in[b] = ($urandom_range(0, pd_div - 1) == 0);
            end
            model_step();
            tick();
            check("random", 16'(obs()), 16'(m_exp));
        end

`ifdef MON_SEL_RR_EN
        begin
            int exp_c;
            reset = 1'b1;
            set_in(1'b0, 3'd0, 4'b0, 4'b0, 4'b0);
            tick();
            reset = 1'b0;
            auto_rr = 1'b1;
            exp_c = RS;
            for (int s = 0; s < 5; s++) begin
                set_in(1'b0, 3'd0, 4'(1 << exp_c), 4'b0, 4'b0); tick();
                set_in(1'b0, 3'd0, 4'b0, 4'b0, 4'(1 << exp_c)); tick();
                set_in(1'b0, 3'd0, 4'b0, 4'b0, 4'b0);
                exp_c = (exp_c + 1) % N;
                k = 0;
                while (k < 10 && cur_sel != 3'(exp_c)) begin
                    k++;
                    tick();
                end
                check($sformatf("rr_step%0d", s), 16'(cur_sel), 16'(exp_c));
            end
            set_in(1'b0, 3'd0, 4'(1 << exp_c), 4'b0, 4'b0); tick();
            set_in(1'b0, 3'd0, 4'b0, 4'b0, 4'(1 << exp_c)); tick();
            set_in(1'b0, 3'd0, 4'b0, 4'b0, 4'b0);
            reset = 1'b1; tick();
            reset = 1'b0;
            check("rr_rst_mid_switch", 16'({cur_sel, switch_pending}), 16'({3'(RS), 1'b0}));
            auto_rr = 1'b0;
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
